// File: rtl/bw_window_counter.sv
// bw_window_counter
//   Per-port bandwidth sampler. It counts transaction bytes and beats over a
//   window framed by one of the decade trigger pulses from the time base. At
//   each window close it hands the totals to a logger through a valid/ready
//   report register.
//
// Ports
//   clk_1000m   : monitor clock
//   perf_rst_n  : asynchronous active-low reset
//   trig_vec    : one-cycle decade trigger pulses (bit0 = 10 ns ... bit8 = 1 s)
//   win_sel     : window select; 0..8 index trig_vec, 9..15 never close
//   mon_en      : monitor enable
//   xact_valid  : a transaction completes this cycle
//   xact_bytes  : byte count of that transaction
//   rpt_valid   : report available
//   rpt_ready   : logger accepts the report
//   rpt_bytes   : bytes in the closed window
//   rpt_xacts   : transactions in the closed window
//   rpt_sat     : a window accumulator saturated
//   rpt_win_id  : window sequence number (wraps)
//   drop_cnt    : reports overwritten before acceptance (saturating)
//   peak_bytes  : largest rpt_bytes since reset or peak_clr
//   peak_clr    : synchronous clear of peak_bytes
module bw_window_counter #(
  parameter int BYTE_W = 16,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 32
) (
  input  logic              clk_1000m,
  input  logic              perf_rst_n,
  input  logic [8:0]        trig_vec,
  input  logic [3:0]        win_sel,
  input  logic              mon_en,
  input  logic              xact_valid,
  input  logic [BYTE_W-1:0] xact_bytes,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [ACC_W-1:0]  rpt_bytes,
  output logic [CNT_W-1:0]  rpt_xacts,
  output logic              rpt_sat,
  output logic [15:0]       rpt_win_id,
  output logic [15:0]       drop_cnt,
  output logic [ACC_W-1:0]  peak_bytes,
  input  logic              peak_clr
);

  // The adder must hold either operand plus a carry. That width covers both
  // the usual case and a narrow ACC_W below BYTE_W.
  localparam int SUM_W = ((ACC_W > BYTE_W) ? ACC_W : BYTE_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         win_sel_q;
  logic [ACC_W-1:0]   acc_bytes_q, acc_bytes_d;
  logic [CNT_W-1:0]   acc_xacts_q, acc_xacts_d;
  logic               acc_sat_q, acc_sat_d;

  logic               rpt_valid_q, rpt_valid_d;
  logic [ACC_W-1:0]   rpt_bytes_q, rpt_bytes_d;
  logic [CNT_W-1:0]   rpt_xacts_q, rpt_xacts_d;
  logic               rpt_sat_q, rpt_sat_d;
  logic [15:0]        rpt_win_id_q, rpt_win_id_d;
  logic [15:0]        next_id_q, next_id_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic [ACC_W-1:0]   peak_q, peak_d;

  logic               win_trig_s;
  logic               sel_chg_s;
  logic               close_s;
  logic [SUM_W-1:0]   sum_bytes_s;
  logic               bytes_ovf_s;
  logic               xacts_ovf_s;
  logic [ACC_W-1:0]   beat_bytes_s;
  logic [CNT_W-1:0]   beat_xacts_s;
  logic               beat_sat_s;

  // Select the window pulse. Out-of-range selects never close a window.
  always_comb begin
    win_trig_s = 1'b0;
    if (win_sel <= 4'd8) begin
      win_trig_s = trig_vec[win_sel];
    end else begin
      win_trig_s = 1'b0;
    end
  end

  assign sel_chg_s = (win_sel != win_sel_q);

  // Compute the accumulators including this cycle's beat, with saturation.
  // The same values feed both the running window and the close-cycle report.
  always_comb begin
    sum_bytes_s  = SUM_W'(acc_bytes_q) + SUM_W'(xact_bytes);
    bytes_ovf_s  = 1'b0;
    xacts_ovf_s  = 1'b0;
    beat_bytes_s = acc_bytes_q;
    beat_xacts_s = acc_xacts_q;
    beat_sat_s   = acc_sat_q;
    if (xact_valid) begin
      bytes_ovf_s  = |sum_bytes_s[SUM_W-1:ACC_W];
      xacts_ovf_s  = (acc_xacts_q == {CNT_W{1'b1}});
      beat_bytes_s = bytes_ovf_s ? {ACC_W{1'b1}} : sum_bytes_s[ACC_W-1:0];
      beat_xacts_s = xacts_ovf_s ? {CNT_W{1'b1}} : (acc_xacts_q + CNT_W'(1));
      beat_sat_s   = acc_sat_q | bytes_ovf_s | xacts_ovf_s;
    end else begin
      bytes_ovf_s  = 1'b0;
      xacts_ovf_s  = 1'b0;
    end
  end

  // Compute the window FSM next state and accumulators, and flag a window close.
  always_comb begin
    state_d     = state_q;
    acc_bytes_d = acc_bytes_q;
    acc_xacts_d = acc_xacts_q;
    acc_sat_d   = acc_sat_q;
    close_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        acc_bytes_d = '0;
        acc_xacts_d = '0;
        acc_sat_d   = 1'b0;
        if (mon_en) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        // The partial window before the first pulse is discarded.
        acc_bytes_d = '0;
        acc_xacts_d = '0;
        acc_sat_d   = 1'b0;
        if (!mon_en) begin
          state_d = ST_IDLE;
        end else if (win_trig_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_RUN: begin
        if (!mon_en) begin
          state_d     = ST_IDLE;
          acc_bytes_d = '0;
          acc_xacts_d = '0;
          acc_sat_d   = 1'b0;
        end else if (sel_chg_s) begin
          // A new window length invalidates the open window. A coincident
          // pulse is ignored.
          state_d     = ST_ARM;
          acc_bytes_d = '0;
          acc_xacts_d = '0;
          acc_sat_d   = 1'b0;
        end else if (win_trig_s) begin
          close_s     = 1'b1;
          acc_bytes_d = '0;
          acc_xacts_d = '0;
          acc_sat_d   = 1'b0;
        end else begin
          acc_bytes_d = beat_bytes_s;
          acc_xacts_d = beat_xacts_s;
          acc_sat_d   = beat_sat_s;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        acc_bytes_d = '0;
        acc_xacts_d = '0;
        acc_sat_d   = 1'b0;
      end
    endcase
  end

  // Compute the report register, sequence id, drop counter and peak.
  always_comb begin
    rpt_valid_d  = rpt_valid_q;
    rpt_bytes_d  = rpt_bytes_q;
    rpt_xacts_d  = rpt_xacts_q;
    rpt_sat_d    = rpt_sat_q;
    rpt_win_id_d = rpt_win_id_q;
    next_id_d    = next_id_q;
    drop_cnt_d   = drop_cnt_q;
    peak_d       = peak_q;
    if (close_s) begin
      rpt_valid_d  = 1'b1;
      rpt_bytes_d  = beat_bytes_s;
      rpt_xacts_d  = beat_xacts_s;
      rpt_sat_d    = beat_sat_s;
      rpt_win_id_d = next_id_q;
      next_id_d    = next_id_q + 16'd1;
      // Overwriting an unaccepted report is a drop. A same-cycle accept is not.
      if (rpt_valid_q && !rpt_ready && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (rpt_valid_q && rpt_ready) begin
      rpt_valid_d = 1'b0;
    end else begin
      rpt_valid_d = rpt_valid_q;
    end
    if (peak_clr) begin
      peak_d = '0;
    end else if (close_s && (beat_bytes_s > peak_q)) begin
      peak_d = beat_bytes_s;
    end else begin
      peak_d = peak_q;
    end
  end

  // Register the FSM state, the accumulators and the previous window select.
  always_ff @(posedge clk_1000m or negedge perf_rst_n) begin
    if (!perf_rst_n) begin
      state_q     <= ST_IDLE;
      win_sel_q   <= 4'd0;
      acc_bytes_q <= '0;
      acc_xacts_q <= '0;
      acc_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_sel_q   <= win_sel;
      acc_bytes_q <= acc_bytes_d;
      acc_xacts_q <= acc_xacts_d;
      acc_sat_q   <= acc_sat_d;
    end
  end

  // Register the report payload, the handshake and the statistics.
  always_ff @(posedge clk_1000m or negedge perf_rst_n) begin
    if (!perf_rst_n) begin
      rpt_valid_q  <= 1'b0;
      rpt_bytes_q  <= '0;
      rpt_xacts_q  <= '0;
      rpt_sat_q    <= 1'b0;
      rpt_win_id_q <= 16'd0;
      next_id_q    <= 16'd0;
      drop_cnt_q   <= 16'd0;
      peak_q       <= '0;
    end else begin
      rpt_valid_q  <= rpt_valid_d;
      rpt_bytes_q  <= rpt_bytes_d;
      rpt_xacts_q  <= rpt_xacts_d;
      rpt_sat_q    <= rpt_sat_d;
      rpt_win_id_q <= rpt_win_id_d;
      next_id_q    <= next_id_d;
      drop_cnt_q   <= drop_cnt_d;
      peak_q       <= peak_d;
    end
  end

  assign rpt_valid  = rpt_valid_q;
  assign rpt_bytes  = rpt_bytes_q;
  assign rpt_xacts  = rpt_xacts_q;
  assign rpt_sat    = rpt_sat_q;
  assign rpt_win_id = rpt_win_id_q;
  assign drop_cnt   = drop_cnt_q;
  assign peak_bytes = peak_q;

endmodule

// File: tb/tb_bw_window_counter.sv
`timescale 1ns/1ps
module tb_bw_window_counter;

  logic        clk_1000m = 1'b0;
  logic        perf_rst_n;
  logic [8:0]  trig_vec;
  logic [3:0]  win_sel;
  logic        mon_en;
  logic        xact_valid;
  logic [15:0] xact_bytes;
  logic        rpt_ready;
  logic        peak_clr;

  logic        rpt_valid;
  logic [39:0] rpt_bytes;
  logic [31:0] rpt_xacts;
  logic        rpt_sat;
  logic [15:0] rpt_win_id;
  logic [15:0] drop_cnt;
  logic [39:0] peak_bytes;

  logic        rpt_valid8;
  logic [7:0]  rpt_bytes8;
  logic [31:0] rpt_xacts8;
  logic        rpt_sat8;
  logic [15:0] rpt_win_id8;
  logic [15:0] drop_cnt8;
  logic [7:0]  peak_bytes8;

  int tests_run = 0;
  int tests_failed = 0;
  int tcnt = 0;

  always #5 clk_1000m = ~clk_1000m;

  bw_window_counter #(.BYTE_W(16), .ACC_W(40), .CNT_W(32)) u_dut (
    .clk_1000m(clk_1000m), .perf_rst_n(perf_rst_n), .trig_vec(trig_vec),
    .win_sel(win_sel), .mon_en(mon_en), .xact_valid(xact_valid),
    .xact_bytes(xact_bytes), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_bytes(rpt_bytes), .rpt_xacts(rpt_xacts), .rpt_sat(rpt_sat),
    .rpt_win_id(rpt_win_id), .drop_cnt(drop_cnt), .peak_bytes(peak_bytes),
    .peak_clr(peak_clr)
  );

  bw_window_counter #(.BYTE_W(16), .ACC_W(8), .CNT_W(32)) u_dut8 (
    .clk_1000m(clk_1000m), .perf_rst_n(perf_rst_n), .trig_vec(trig_vec),
    .win_sel(win_sel), .mon_en(mon_en), .xact_valid(xact_valid),
    .xact_bytes(xact_bytes), .rpt_valid(rpt_valid8), .rpt_ready(rpt_ready),
    .rpt_bytes(rpt_bytes8), .rpt_xacts(rpt_xacts8), .rpt_sat(rpt_sat8),
    .rpt_win_id(rpt_win_id8), .drop_cnt(drop_cnt8), .peak_bytes(peak_bytes8),
    .peak_clr(peak_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive the decade triggers for the current cycle index, then advance one edge.
  task automatic step();
    longint pw;
    pw = 1;
    trig_vec = 9'd0;
    for (int k = 0; k < 9; k++) begin
      pw = pw * 10;
      if ((longint'(tcnt) % pw) == pw - 1) trig_vec[k] = 1'b1;
    end
    @(posedge clk_1000m);
    #1;
    tcnt++;
  endtask

  task automatic wait_rpt(input string tag, input int bound);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((rpt_valid !== 1'b1) && (n < bound));
    check(tag, {63'd0, rpt_valid}, 64'd1);
  endtask

  initial begin
    perf_rst_n = 1'b0;
    trig_vec   = 9'd0;
    win_sel    = 4'd0;
    mon_en     = 1'b0;
    xact_valid = 1'b0;
    xact_bytes = 16'd0;
    rpt_ready  = 1'b0;
    peak_clr   = 1'b0;
    step(); step();
    perf_rst_n = 1'b1;
    tcnt = 0;
    step();
    check("reset_valid", {63'd0, rpt_valid}, 64'd0);
    check("reset_bytes", {24'd0, rpt_bytes}, 64'd0);
    check("reset_id", {48'd0, rpt_win_id}, 64'd0);
    check("reset_drop", {48'd0, drop_cnt}, 64'd0);

    // 1 us windows, 64 bytes every cycle
    tcnt = 0;
    mon_en = 1'b1; win_sel = 4'd2; xact_valid = 1'b1; xact_bytes = 16'd64; rpt_ready = 1'b1;
    wait_rpt("t1_wait0", 2100);
    check("t1_first_time", tcnt, 64'd2000);
    check("t1_bytes0", {24'd0, rpt_bytes}, 64'd64000);
    check("t1_xacts0", {32'd0, rpt_xacts}, 64'd1000);
    check("t1_sat0", {63'd0, rpt_sat}, 64'd0);
    check("t1_id0", {48'd0, rpt_win_id}, 64'd0);
    for (int i = 1; i < 3; i++) begin
      wait_rpt("t1_wait", 1100);
      check("t1_bytes", {24'd0, rpt_bytes}, 64'd64000);
      check("t1_xacts", {32'd0, rpt_xacts}, 64'd1000);
      check("t1_id", {48'd0, rpt_win_id}, 64'(i));
    end

    // beat in the trig cycle and beat in the following cycle
    xact_valid = 1'b0; win_sel = 4'd0;
    for (int i = 0; i < 25; i++) step();
    while ((tcnt % 10) != 9) step();
    xact_valid = 1'b1; xact_bytes = 16'd8;
    step();
    check("t2_valid_k", {63'd0, rpt_valid}, 64'd1);
    check("t2_bytes_k", {24'd0, rpt_bytes}, 64'd8);
    check("t2_xacts_k", {32'd0, rpt_xacts}, 64'd1);
    check("t2_id_k", {48'd0, rpt_win_id}, 64'd4);
    xact_bytes = 16'd4;
    step();
    check("t2_valid_drop", {63'd0, rpt_valid}, 64'd0);
    xact_valid = 1'b0;
    wait_rpt("t2_wait", 20);
    check("t2_bytes_k1", {24'd0, rpt_bytes}, 64'd4);
    check("t2_xacts_k1", {32'd0, rpt_xacts}, 64'd1);
    check("t2_id_k1", {48'd0, rpt_win_id}, 64'd5);
    check("t2_peak", {24'd0, peak_bytes}, 64'd64000);

    // asynchronous reset with a pending report and a nonzero peak
    rpt_ready = 1'b0;
    wait_rpt("t6_wait", 20);
    #2;
    perf_rst_n = 1'b0;
    #1;
    check("t6_valid", {63'd0, rpt_valid}, 64'd0);
    check("t6_bytes", {24'd0, rpt_bytes}, 64'd0);
    check("t6_xacts", {32'd0, rpt_xacts}, 64'd0);
    check("t6_id", {48'd0, rpt_win_id}, 64'd0);
    check("t6_peak", {24'd0, peak_bytes}, 64'd0);
    check("t6_sat", {63'd0, rpt_sat}, 64'd0);
    mon_en = 1'b0; win_sel = 4'd0; rpt_ready = 1'b1; xact_valid = 1'b0;
    step(); step();
    perf_rst_n = 1'b1;
    tcnt = 0;

    // 10-cycle windows with the logger stalled
    mon_en = 1'b1;
    wait_rpt("t3_wait", 40);
    check("t3_first_time", tcnt, 64'd20);
    check("t3_first_id", {48'd0, rpt_win_id}, 64'd0);
    xact_valid = 1'b1; xact_bytes = 16'd3;
    step();
    rpt_ready = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("t3_hold_valid", {63'd0, rpt_valid}, 64'd1);
    check("t3_hold_id", {48'd0, rpt_win_id}, 64'd1);
    check("t3_hold_drop", {48'd0, drop_cnt}, 64'd0);
    check("t3_hold_bytes", {24'd0, rpt_bytes}, 64'd30);
    for (int i = 0; i < 26; i++) step();
    check("t3_valid", {63'd0, rpt_valid}, 64'd1);
    check("t3_id", {48'd0, rpt_win_id}, 64'd3);
    check("t3_drop", {48'd0, drop_cnt}, 64'd2);
    check("t3_xacts", {32'd0, rpt_xacts}, 64'd10);
    step(); step(); step();
    rpt_ready = 1'b1;
    step();
    check("t3_acc_close_valid", {63'd0, rpt_valid}, 64'd1);
    check("t3_acc_close_id", {48'd0, rpt_win_id}, 64'd4);
    check("t3_acc_close_drop", {48'd0, drop_cnt}, 64'd2);
    step();
    check("t3_accepted", {63'd0, rpt_valid}, 64'd0);

    // window select change in RUN, then a one-cycle mon_en drop
    xact_bytes = 16'd1; win_sel = 4'd1;
    step();
    wait_rpt("t5_wait_a", 300);
    check("t5_a_time", tcnt, 64'd200);
    check("t5_a_bytes", {24'd0, rpt_bytes}, 64'd100);
    check("t5_a_xacts", {32'd0, rpt_xacts}, 64'd100);
    check("t5_a_id", {48'd0, rpt_win_id}, 64'd5);
    for (int i = 0; i < 50; i++) step();
    mon_en = 1'b0;
    step();
    mon_en = 1'b1;
    wait_rpt("t5_wait_b", 300);
    check("t5_b_time", tcnt, 64'd400);
    check("t5_b_bytes", {24'd0, rpt_bytes}, 64'd100);
    check("t5_b_id", {48'd0, rpt_win_id}, 64'd6);
    check("t5_peak", {24'd0, peak_bytes}, 64'd100);
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    check("t5_peak_clr", {24'd0, peak_bytes}, 64'd0);

    // saturation on the 8-bit accumulator instance
    win_sel = 4'd0; xact_valid = 1'b0;
    wait_rpt("t4_wait0", 40);
    check("t4_time0", tcnt, 64'd420);
    check("t4_id0", {48'd0, rpt_win_id}, 64'd7);
    xact_valid = 1'b1; xact_bytes = 16'd200;
    step(); step();
    xact_valid = 1'b0;
    wait_rpt("t4_wait1", 20);
    check("t4_bytes_wide", {24'd0, rpt_bytes}, 64'd400);
    check("t4_sat_wide", {63'd0, rpt_sat}, 64'd0);
    check("t4_bytes8", {56'd0, rpt_bytes8}, 64'd255);
    check("t4_sat8", {63'd0, rpt_sat8}, 64'd1);
    check("t4_xacts8", {32'd0, rpt_xacts8}, 64'd2);
    wait_rpt("t4_wait2", 20);
    check("t4_next_sat8", {63'd0, rpt_sat8}, 64'd0);
    check("t4_next_bytes8", {56'd0, rpt_bytes8}, 64'd0);
    check("t4_peak8", {56'd0, peak_bytes8}, 64'd255);
    check("t4_peak_wide", {24'd0, peak_bytes}, 64'd400);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bw_window_counter.md
# bw_window_counter

Trigger-driven bandwidth sampler for the performance-monitor model. It consumes the one-cycle decade trigger pulses produced by the shared time-base interface (10 ns … 1 s). It accumulates transaction bytes and counts over the selected window, and hands each closed window's totals to a logger through a valid/ready report port. One instance sits per monitored bus port, on the same clk_1000m domain as the time base.

## Interface
- BYTE_W, 16: width of per-transaction byte count.
- ACC_W, 40: width of window byte accumulator and peak register.
- CNT_W, 32: width of window transaction counter.

- clk_1000m  in  1  monitor clock (1 GHz model clock).
- perf_rst_n  in  1  asynchronous, active-low reset.
- trig_vec  in  9  one-cycle trigger pulses; bit0=10ns, 1=100ns, 2=1us, 3=10us, 4=100us, 5=1ms, 6=10ms, 7=100ms, 8=1s.
- win_sel  in  4  window select, 0..8 index trig_vec; 9..15 = no window (never closes).
- mon_en  in  1  monitor enable.
- xact_valid  in  1  one transaction completes this cycle.
- xact_bytes  in  BYTE_W  bytes of that transaction (ignored when xact_valid=0).
- rpt_valid  out  1  report available.
- rpt_ready  in  1  logger accepts report.
- rpt_bytes  out  ACC_W  bytes in closed window.
- rpt_xacts  out  CNT_W  transactions in closed window.
- rpt_sat  out  1  rpt_bytes or rpt_xacts saturated in that window.
- rpt_win_id  out  16  window sequence number, wraps 0xFFFF->0.
- drop_cnt  out  16  reports overwritten before acceptance; saturates at 0xFFFF.
- peak_bytes  out  ACC_W  largest rpt_bytes seen since reset/peak_clr.
- peak_clr  in  1  synchronous clear of peak_bytes.

## Operation
- Window pulse: win_trig = trig_vec[win_sel] when win_sel<=8, else 0.
- States:
  - IDLE: mon_en=0; accumulators held at 0. mon_en=1 -> ARM.
  - ARM: waits for first win_trig, discarding the partial window. On win_trig -> RUN with accumulators cleared.
  - RUN: accumulates. On win_trig it closes the window, loads the report, and starts a new window.
- Any state: mon_en=0 -> IDLE next cycle. No report is produced for the open window.
- win_sel change while in RUN -> ARM; the open window is discarded. A win_trig in that same cycle is ignored.
- Accumulate: in RUN with xact_valid=1, acc_bytes += xact_bytes and acc_xacts += 1.
  - Each accumulator saturates at all-ones and sets a sat flag for the window.
- Close cycle: a transaction in the trig cycle belongs to the closing window.
  - Report fields are loaded with acc+current beat.
  - Accumulators restart at 0 the next cycle.
  - A beat in the cycle after trig belongs to the new window.
- Report register:
  - On close, rpt_* are loaded, rpt_valid is set, and rpt_win_id increments. The first report after reset carries id 0.
  - If rpt_valid=1 and rpt_ready=0 when a new close occurs, the report is overwritten with the new window and drop_cnt increments.
  - If close and accept happen in the same cycle, the new report is loaded, rpt_valid stays 1, and there is no drop.
- peak_bytes updates to the new rpt_bytes on load when it is greater. peak_clr has priority over the update in the same cycle.

## Timing
- Reset values: state IDLE, rpt_valid=0, rpt_bytes=0, rpt_xacts=0, rpt_sat=0, rpt_win_id=0 (internal next-id=0), drop_cnt=0, peak_bytes=0, accumulators 0.
- Latency: win_trig at cycle N -> rpt_valid=1 and rpt_* valid at N+1.
- Handshake:
  - rpt_valid held with stable payload until the cycle rpt_valid & rpt_ready.
  - rpt_valid drops next cycle unless a new close coincides.
  - rpt_ready with rpt_valid=0 is ignored.
- Back-to-back windows: with win_sel=0, a close occurs every 10 cycles. A logger holding rpt_ready=1 sees a report every 10 cycles.
- Reset asserted mid-window or mid-handshake clears everything asynchronously. After release the block starts in IDLE.
- mon_en drop does not clear a pending report; it remains until accepted.

## Test plan
- Enable, win_sel=2 (1 us), xact_valid=1 every cycle with xact_bytes=64, rpt_ready=1.
  - -> after the first discarded partial window, each report has rpt_bytes=64000, rpt_xacts=1000, rpt_sat=0, with rpt_win_id incrementing 0,1,2.
- Beat in trig cycle (bytes=8) and beat in the next cycle (bytes=4), no other traffic.
  - -> window k reports 8 with xacts 1; window k+1 reports 4 with xacts 1.
- win_sel=0, rpt_ready=0 for 35 cycles.
  - -> rpt_valid held, payload replaced each 10 cycles, drop_cnt=2 or 3 matching closes-1, rpt_win_id reflects the latest window.
- ACC_W override 8, bytes=200 twice in one window.
  - -> rpt_bytes=0xFF, rpt_sat=1; the next window is rpt_sat=0.
- win_sel change 0->1 in RUN, and mon_en toggled low for 1 cycle.
  - -> no report for the interrupted window; the next report covers only a full 100-cycle window.
- perf_rst_n pulsed low while rpt_valid=1 and peak_bytes nonzero.
  - -> all outputs 0 immediately; after release, the first report has rpt_win_id=0.
